vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning the VRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning the VRAM word width (pixels per word at 1 bpp).
REQ-003 SHALL have port CLK_VGA  in  1  40 MHz clock; the only clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port vga_req  in  1  single-cycle scanout fetch pulse.
REQ-006 SHALL have port vga_addr  in  ADDR_W  scanout word address, valid with vga_req.
REQ-007 SHALL have port vga_data  out  DATA_W  fetched scanout word.
REQ-008 SHALL have port vga_valid  out  1  vga_data valid pulse.
REQ-009 SHALL have port cpu_req  in  1  CPU access request, held until cpu_ack.
REQ-010 SHALL have port cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-011 SHALL have port cpu_addr  in  ADDR_W  CPU word address; stable while cpu_req is high.
REQ-012 SHALL have port cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req is high.
REQ-013 SHALL have port cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack on reads.
REQ-014 SHALL have port cpu_ack  out  1  single-cycle access completion pulse.
REQ-015 SHALL have ports mem_addr (out, ADDR_W), mem_we (out, 1), mem_wdata (out, DATA_W), mem_rdata (in, DATA_W) to a single-port BRAM with 1-cycle registered read latency.

Function
REQ-016 SHALL drive at most one memory access per cycle; mem_addr, mem_we and mem_wdata SHALL be combinational from the current-cycle grant.
REQ-017 SHALL grant vga_req in the same cycle it is asserted, unconditionally (fixed VGA priority).
REQ-018 SHALL assert vga_valid exactly 1 cycle after a VGA grant, with vga_data = mem_rdata.
REQ-019 SHALL use FSM states IDLE and CPU_PEND.
REQ-020 IDLE: cpu_req=1 and vga_req=0 SHALL issue the CPU access (mem_we=cpu_we) and transition to CPU_PEND.
REQ-021 CPU_PEND: SHALL assert cpu_ack for one cycle, with cpu_rdata = mem_rdata on reads, and return to IDLE.
REQ-022 SHALL NOT issue a CPU access in a cycle where cpu_ack is high; back-to-back CPU accesses occur at most every 2 cycles.
REQ-023 vga_req and cpu_req in the same cycle: VGA SHALL be granted, CPU held in IDLE, and the CPU access SHALL be issued on the first later cycle with vga_req=0.
REQ-024 A VGA fetch SHALL be accepted in CPU_PEND in the same cycle as cpu_ack, with no corruption of either data path.
REQ-025 VGA read and CPU write to the same address in the same cycle: VGA SHALL return the pre-write data, and the write SHALL complete 1 cycle later.
REQ-026 When there is no grant, mem_we SHALL be 0 and mem_addr SHALL hold its last value.

Reset
REQ-027 On reset SHALL enter IDLE and zero vga_valid, cpu_ack, mem_we, mem_addr, mem_wdata, vga_data and cpu_rdata.
REQ-028 Reset in CPU_PEND SHALL drop the pending access with no cpu_ack; reset in the cycle after a VGA grant SHALL suppress vga_valid.

Configuration
REQ-029 With macro VRAM_ARB_STATS_EN defined, SHALL add input stats_clr (1) and output cpu_stall_cnt (16).
REQ-030 With VRAM_ARB_STATS_EN, cpu_stall_cnt SHALL count cycles where cpu_req=1 in IDLE but is blocked by vga_req, saturating at 0xFFFF.
REQ-031 With VRAM_ARB_STATS_EN, cpu_stall_cnt SHALL be cleared by reset or stats_clr; stats_clr SHALL win over a same-cycle increment.
REQ-032 Without VRAM_ARB_STATS_EN, SHALL omit those ports and logic, with otherwise identical cycle behaviour.

Verification
REQ-033 Bench SHALL cover: CPU write addr 0x0010 data 0xA5A5, then read 0x0010 -> write ack at cycle+1, read ack 2 cycles later with cpu_rdata=0xA5A5.
REQ-034 Bench SHALL cover: vga_req plus cpu_req read at same cycle T -> vga_valid at T+1, CPU issued at T+1, cpu_ack at T+2.
REQ-035 Bench SHALL cover: vga_req every cycle for 8 cycles with cpu_req held -> 8 vga_valid pulses, CPU acked 2 cycles after the VGA burst ends, cpu_stall_cnt=8 with stats enabled.
REQ-036 Bench SHALL cover: same-address VGA read plus CPU write 0x1234 over old 0xFFFF -> vga_data=0xFFFF, a later read returns 0x1234.
REQ-037 Bench SHALL cover: reset asserted in CPU_PEND -> no cpu_ack, all outputs 0 the next cycle, FSM in IDLE.
REQ-038 Bench SHALL cover: stall counter preloaded to 0xFFFF by a long VGA burst -> holds at 0xFFFF, then reads 0 the cycle after stats_clr.

Source files
------------

// File: rtl/vram_arbiter.sv
// VRAM arbiter: one single-port BRAM shared by VGA scanout and a CPU port.
// VGA fetches always win and are granted in the cycle they arrive.
// A CPU access takes two cycles: issue, then acknowledge.
// Optional fetch-stall statistics are enabled with `define VRAM_ARB_STATS_EN.
module vram_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              CLK_VGA,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       cpu_stall_cnt
`endif
);

  typedef enum logic {
    IDLE     = 1'b0,
    CPU_PEND = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_vga_valid;
  logic              r_cpu_ack;
  logic              r_cpu_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_vga_gnt;
  logic              w_cpu_gnt;

  // No access is granted while reset is held so the BRAM is never written
  // during reset; the CPU only gets the port when VGA does not want it.
  assign w_vga_gnt = vga_req & ~reset;
  assign w_cpu_gnt = (r_state == IDLE) & cpu_req & ~vga_req & ~reset;

  // Memory port follows the current-cycle grant; address and write data hold otherwise.
  always_comb begin
    mem_addr  = r_mem_addr;
    mem_wdata = r_mem_wdata;
    mem_we    = 1'b0;
    if (w_vga_gnt) begin
      mem_addr = vga_addr;
    end else if (w_cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end
  end

  // Arbitration FSM plus the registered response strobes.
  always_ff @(posedge CLK_VGA) begin
    if (reset) begin
      r_state     <= IDLE;
      r_vga_valid <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_cpu_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_vga_valid <= w_vga_gnt;
      r_mem_addr  <= mem_addr;
      r_mem_wdata <= mem_wdata;
      case (r_state)
        IDLE: begin
          if (w_cpu_gnt) begin
            r_state   <= CPU_PEND;
            r_cpu_ack <= 1'b1;
            r_cpu_rd  <= ~cpu_we;
          end else begin
            r_cpu_ack <= 1'b0;
          end
        end
        CPU_PEND: begin
          r_state   <= IDLE;
          r_cpu_ack <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_cpu_ack <= 1'b0;
        end
      endcase
    end
  end

  // Read data arrives from the BRAM one cycle after the grant, aligned with
  // the strobes. A reset landing on that cycle cancels the response.
  assign vga_valid = r_vga_valid & ~reset;
  assign cpu_ack   = r_cpu_ack & ~reset;
  assign vga_data  = vga_valid ? mem_rdata : '0;
  assign cpu_rdata = (cpu_ack & r_cpu_rd) ? mem_rdata : '0;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  // Count idle CPU requests pushed back by VGA; clear beats increment, saturates.
  always_ff @(posedge CLK_VGA) begin
    if (reset || stats_clr) begin
      r_stall_cnt <= '0;
    end else if ((r_state == IDLE) && cpu_req && vga_req && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign cpu_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a driver issues VGA fetches and CPU
// commands while a reference memory predicts each response; a monitor
// checks every vga_valid / cpu_ack pulse against the expectation queues.
// Stall-counter checks are compiled in when VRAM_ARB_STATS_EN is defined.
module tb_vram_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;

  logic          CLK_VGA = 1'b0;
  logic          reset;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_data;
  logic          vga_valid;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic          stats_clr;
  logic [15:0]   cpu_stall_cnt;
`endif

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK_VGA   (CLK_VGA),
    .reset     (reset),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .vga_data  (vga_data),
    .vga_valid (vga_valid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef VRAM_ARB_STATS_EN
    ,
    .stats_clr     (stats_clr),
    .cpu_stall_cnt (cpu_stall_cnt)
`endif
  );

  always #5 CLK_VGA = ~CLK_VGA;

  int cyc = 0;
  always @(posedge CLK_VGA) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(input int i);
    return 16'((i * 257) ^ 16'h5A3C);
  endfunction

  // Single-port BRAM with registered read, read-before-write.
  logic [DW-1:0] bram [0:255];
  logic          preload;
  always @(posedge CLK_VGA) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) bram[i] <= init_word(i);
    end else if (mem_we) begin
      bram[mem_addr[7:0]] <= mem_wdata;
    end
    mem_rdata <= bram[mem_addr[7:0]];
  end

  typedef struct { int cyc; logic [15:0] data; } vexp_t;
  typedef struct { int cyc; logic we; logic [15:0] data; } cexp_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [15:0] wdata; } cmd_t;

  vexp_t vq[$];
  cexp_t cq[$];
  cmd_t  cmdq[$];

  int checks = 0;
  int errors = 0;
  bit quiet  = 1'b0;

  // Reference model: memory contents as seen by the ports plus the CPU request phase.
  logic [15:0] ref_mem [0:255];
  int   cpu_ph  = 0;    // 0 no request, 1 requesting, 2 issued and awaiting ack
  int   ack_cyc = 0;
  int   m_stall = 0;
  cmd_t cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; inputs are applied just after the rising edge.
  task automatic step(input bit v, input logic [AW-1:0] va, input bit clr);
    cexp_t ce;
    vexp_t ve;
`ifdef VRAM_ARB_STATS_EN
    chk("stall_cnt", {16'd0, cpu_stall_cnt}, 32'(m_stall));
`endif
    if (cpu_ph == 2 && cyc == ack_cyc) begin
      cpu_req = 1'b0;
      cpu_ph  = 0;
    end else if (cpu_ph == 0 && cmdq.size() > 0) begin
      cur       = cmdq.pop_front();
      cpu_req   = 1'b1;
      cpu_we    = cur.we;
      cpu_addr  = cur.addr;
      cpu_wdata = cur.wdata;
      cpu_ph    = 1;
    end
    if (cpu_ph == 1) begin
      if (!v) begin
        ce.cyc  = cyc + 1;
        ce.we   = cur.we;
        ce.data = ref_mem[cur.addr[7:0]];
        if (cur.we) ref_mem[cur.addr[7:0]] = cur.wdata;
        cq.push_back(ce);
        cpu_ph  = 2;
        ack_cyc = cyc + 1;
      end else if (m_stall != 65535) begin
        m_stall++;
      end
    end
`ifdef VRAM_ARB_STATS_EN
    stats_clr = clr;
    if (clr) m_stall = 0;
`endif
    vga_req  = v;
    vga_addr = va;
    if (v) begin
      ve.cyc  = cyc + 1;
      ve.data = ref_mem[va[7:0]];
      vq.push_back(ve);
    end
    @(posedge CLK_VGA);
    #1;
  endtask

  task automatic idle_outputs_zero(input string tag);
    #1;
    chk({tag, "_vga_valid"}, 32'(vga_valid), 0);
    chk({tag, "_cpu_ack"},   32'(cpu_ack),   0);
    chk({tag, "_mem_we"},    32'(mem_we),    0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_vga_data"},  32'(vga_data),  0);
    chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 0);
  endtask

  // Synchronous reset for n cycles; responses due in the reset cycle are cancelled.
  task automatic do_reset(input int n);
    reset   = 1'b1;
    vga_req = 1'b0;
    cpu_req = 1'b0;
`ifdef VRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    #1;
    chk("vga_valid_in_reset", 32'(vga_valid), 0);
    chk("cpu_ack_in_reset",   32'(cpu_ack),   0);
    while (vq.size() > 0 && vq[$].cyc >= cyc) void'(vq.pop_back());
    while (cq.size() > 0 && cq[$].cyc >= cyc) void'(cq.pop_back());
    cpu_ph  = 0;
    m_stall = 0;
    repeat (n) begin
      @(posedge CLK_VGA);
      #1;
    end
    reset = 1'b0;
    idle_outputs_zero("after_reset");
  endtask

  function automatic cmd_t mk(input logic we, input int addr, input logic [15:0] wd);
    cmd_t c;
    c.we    = we;
    c.addr  = AW'(addr);
    c.wdata = wd;
    return c;
  endfunction

  // Monitor: pops and compares on every response pulse, flags missing ones.
  vexp_t mv;
  cexp_t mc;
  always @(negedge CLK_VGA) begin
    while (vq.size() > 0 && vq[0].cyc < cyc) begin
      mv = vq.pop_front();
      checks++; errors++;
      $display("FAIL vga_missing: no vga_valid, expected at cycle %0d data 0x%0h", mv.cyc, mv.data);
    end
    while (cq.size() > 0 && cq[0].cyc < cyc) begin
      mc = cq.pop_front();
      checks++; errors++;
      $display("FAIL cpu_missing: no cpu_ack, expected at cycle %0d", mc.cyc);
    end
    if (vga_valid) begin
      if (vq.size() == 0) begin
        checks++; errors++;
        $display("FAIL vga_unexpected: vga_valid with data 0x%0h at cycle %0d, none expected", vga_data, cyc);
      end else begin
        mv = vq.pop_front();
        chk("vga_cycle", 32'(cyc), 32'(mv.cyc));
        chk("vga_data", 32'(vga_data), 32'(mv.data));
        if (!quiet) $display("cycle %0d: VGA fetch data 0x%04h (model 0x%04h)", cyc, vga_data, mv.data);
      end
    end
    if (cpu_ack) begin
      chk("no_issue_on_ack", 32'(mem_we), 0);
      if (cq.size() == 0) begin
        checks++; errors++;
        $display("FAIL cpu_unexpected: cpu_ack at cycle %0d, none expected", cyc);
      end else begin
        mc = cq.pop_front();
        chk("cpu_ack_cycle", 32'(cyc), 32'(mc.cyc));
        if (!mc.we) chk("cpu_rdata", 32'(cpu_rdata), 32'(mc.data));
        $display("cycle %0d: CPU %s ack rdata 0x%04h (model 0x%04h)", cyc, mc.we ? "write" : "read",
                 cpu_rdata, mc.we ? 16'h0 : mc.data);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    preload   = 1'b1;
    vga_req   = 1'b0;
    vga_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
`ifdef VRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    @(posedge CLK_VGA);
    #1;
    preload = 1'b0;
    do_reset(2);

    // Write then read back at the same address.
    cmdq.push_back(mk(1'b1, 16'h0010, 16'hA5A5));
    cmdq.push_back(mk(1'b0, 16'h0010, 16'h0000));
    repeat (5) step(1'b0, '0, 1'b0);

    // VGA and CPU read arrive together.
    cmdq.push_back(mk(1'b0, 16'h0041, 16'h0000));
    step(1'b1, AW'(16'h0040), 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);

    // VGA fetch accepted during the CPU acknowledge cycle.
    cmdq.push_back(mk(1'b0, 16'h0033, 16'h0000));
    step(1'b0, '0, 1'b0);
    step(1'b1, AW'(16'h0034), 1'b0);
    repeat (2) step(1'b0, '0, 1'b0);

    // Eight-cycle VGA burst with the CPU held off.
`ifdef VRAM_ARB_STATS_EN
    step(1'b0, '0, 1'b1);
`endif
    cmdq.push_back(mk(1'b0, 16'h0050, 16'h0000));
    for (int i = 0; i < 8; i++) step(1'b1, AW'(16'h0080 + i), 1'b0);
`ifdef VRAM_ARB_STATS_EN
    chk("stall_after_burst8", {16'd0, cpu_stall_cnt}, 32'd8);
`endif
    repeat (4) step(1'b0, '0, 1'b0);

    // Same-address VGA read racing a CPU write.
    cmdq.push_back(mk(1'b1, 16'h0020, 16'hFFFF));
    repeat (3) step(1'b0, '0, 1'b0);
    cmdq.push_back(mk(1'b1, 16'h0020, 16'h1234));
    step(1'b1, AW'(16'h0020), 1'b0);
    cmdq.push_back(mk(1'b0, 16'h0020, 16'h0000));
    repeat (5) step(1'b0, '0, 1'b0);

    // Reset the cycle after a VGA grant.
    step(1'b1, AW'(16'h0005), 1'b0);
    do_reset(1);

    // Reset while the CPU access is pending, then confirm the FSM is idle.
    cmdq.push_back(mk(1'b0, 16'h0007, 16'h0000));
    step(1'b0, '0, 1'b0);
    do_reset(1);
    cmdq.push_back(mk(1'b0, 16'h0008, 16'h0000));
    repeat (3) step(1'b0, '0, 1'b0);

    // Randomized traffic over a small address window to force collisions.
    for (int i = 0; i < 400; i++) begin
      if (cmdq.size() < 2 && ($urandom % 3) == 0)
        cmdq.push_back(mk(1'($urandom % 2), int'($urandom_range(0, 31)), 16'($urandom)));
      step(($urandom % 100) < 40, AW'($urandom_range(0, 31)), ($urandom % 50) == 0);
    end
    repeat (6) step(1'b0, '0, 1'b0);

`ifdef VRAM_ARB_STATS_EN
    // Drive the stall counter into saturation, then clear it under traffic.
    quiet = 1'b1;
    cmdq.push_back(mk(1'b0, 16'h0011, 16'h0000));
    repeat (65540) step(1'b1, AW'($urandom_range(0, 255)), 1'b0);
    quiet = 1'b0;
    chk("stall_saturated", {16'd0, cpu_stall_cnt}, 32'hFFFF);
    step(1'b1, AW'(16'h0001), 1'b0);
    chk("stall_holds", {16'd0, cpu_stall_cnt}, 32'hFFFF);
    step(1'b1, AW'(16'h0002), 1'b1);
    chk("stall_cleared", {16'd0, cpu_stall_cnt}, 32'h0);
    repeat (4) step(1'b0, '0, 1'b0);
`endif

    @(negedge CLK_VGA);
    chk("vga_queue_drained", 32'(vq.size()), 0);
    chk("cpu_queue_drained", 32'(cq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
